// File: rtl/address_counter_pkg.sv
// rtl/address_counter_pkg.sv - shared widths, address-mode codes and state type for the address counter
package address_counter_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int ADMD_WIDTH = 3;

  // Address mode codes; every code other than ADMD_PRUD counts linearly
  localparam logic [ADMD_WIDTH-1:0] ADMD_LIUD = 3'd0;
  localparam logic [ADMD_WIDTH-1:0] ADMD_PRUD = 3'd5;

  localparam logic ADDR_UP = 1'b1;

  localparam logic [7:0] ACNT_LFSR_TAPS = 8'hB8;

  typedef enum logic {
    ACNT_IDLE = 1'b0,
    ACNT_RUN  = 1'b1
  } acnt_state_e;

endpackage

// File: rtl/address_lfsr_step.sv
// rtl/address_lfsr_step.sv - combinational de Bruijn LFSR successor/predecessor
module address_lfsr_step #(
  parameter int              TASW = 8,
  parameter logic [TASW-1:0] TAPS = 8'hB8
) (
  input  logic [TASW-1:0] s_i,
  input  logic            dir_up_i,
  output logic [TASW-1:0] s_o
);

  logic fwd_bit;
  logic rev_bit;

  // Forward: Fibonacci feedback, XORed with "low bits all zero" so the 0 state is spliced in after 1<<(TASW-1).
  // Reverse: the shifted-out bit b feeds the parity through the top tap, so solve for b directly.
  always_comb begin
    fwd_bit = (^(s_i & TAPS)) ^ (s_i[TASW-2:0] == '0);
    rev_bit = s_i[0] ^ (^(s_i[TASW-1:1] & TAPS[TASW-2:0])) ^ (s_i[TASW-1:1] == '0);
    s_o     = dir_up_i ? {s_i[TASW-2:0], fwd_bit} : {rev_bit, s_i[TASW-1:1]};
  end

endmodule

// File: rtl/address_counter.sv
// rtl/address_counter.sv - PMBIST raw address counter; ADDR_CNT_MAXADDR_EN adds max_addr_in
module address_counter
  import address_counter_pkg::*;
#(
  parameter int              TASW      = ADDR_WIDTH,
  parameter logic [TASW-1:0] LFSR_TAPS = TASW'(ACNT_LFSR_TAPS)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic                  step_in,
  input  logic [ADMD_WIDTH-1:0] admd_in,
  input  logic                  updwn_in,
`ifdef ADDR_CNT_MAXADDR_EN
  input  logic [TASW-1:0]       max_addr_in,
`endif
  output logic [TASW-1:0]       tas_out,
  output logic                  busy_out,
  output logic                  last_out,
  output logic                  done_out
);

  localparam logic [TASW-1:0] ALL_ONES  = '1;
  localparam logic [TASW-1:0] PRUD_HEAD = TASW'(1) << (TASW - 1);

  acnt_state_e     state_q, state_d;
  logic [TASW-1:0] tas_q, tas_d;
  logic            done_q, done_d;
  logic            prud_q, prud_d;
  logic            up_q, up_d;
  logic [TASW-1:0] max_lim;
  logic [TASW-1:0] max_start;
  logic [TASW-1:0] first_addr;
  logic [TASW-1:0] terminal;
  logic [TASW-1:0] lfsr_nxt;
  logic [TASW-1:0] lin_nxt;
  logic            at_last;

`ifdef ADDR_CNT_MAXADDR_EN
  logic [TASW-1:0] max_q, max_d;
  assign max_lim   = max_q;
  assign max_start = max_addr_in;
`else
  assign max_lim   = ALL_ONES;
  assign max_start = ALL_ONES;
`endif

  address_lfsr_step #(
    .TASW (TASW),
    .TAPS (LFSR_TAPS)
  ) u_lfsr_step (
    .s_i      (tas_q),
    .dir_up_i (up_q),
    .s_o      (lfsr_nxt)
  );

  // First address of a new element (from live inputs) and terminal address of the latched element
  always_comb begin
    if (admd_in == ADMD_PRUD) begin
      first_addr = (updwn_in == ADDR_UP) ? '0 : PRUD_HEAD;
    end else begin
      first_addr = (updwn_in == ADDR_UP) ? '0 : max_start;
    end
    if (prud_q) begin
      terminal = up_q ? PRUD_HEAD : '0;
    end else begin
      terminal = up_q ? max_lim : '0;
    end
    lin_nxt = up_q ? (tas_q + TASW'(1)) : (tas_q - TASW'(1));
    at_last = (state_q == ACNT_RUN) && (tas_q == terminal);
  end

  // Next-state: start (re)loads the element and wins over step; step on the terminal address ends it
  always_comb begin
    state_d = state_q;
    tas_d   = tas_q;
    done_d  = 1'b0;
    prud_d  = prud_q;
    up_d    = up_q;
`ifdef ADDR_CNT_MAXADDR_EN
    max_d   = max_q;
`endif
    if (start_in) begin
      state_d = ACNT_RUN;
      tas_d   = first_addr;
      prud_d  = (admd_in == ADMD_PRUD);
      up_d    = (updwn_in == ADDR_UP);
`ifdef ADDR_CNT_MAXADDR_EN
      max_d   = max_addr_in;
`endif
    end else if (step_in && state_q == ACNT_RUN) begin
      if (at_last) begin
        state_d = ACNT_IDLE;
        done_d  = 1'b1;
      end else begin
        tas_d = prud_q ? lfsr_nxt : lin_nxt;
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ACNT_IDLE;
      tas_q   <= '0;
      done_q  <= 1'b0;
      prud_q  <= (ADMD_LIUD == ADMD_PRUD);
      up_q    <= ADDR_UP;
`ifdef ADDR_CNT_MAXADDR_EN
      max_q   <= ALL_ONES;
`endif
    end else begin
      state_q <= state_d;
      tas_q   <= tas_d;
      done_q  <= done_d;
      prud_q  <= prud_d;
      up_q    <= up_d;
`ifdef ADDR_CNT_MAXADDR_EN
      max_q   <= max_d;
`endif
    end
  end

  assign tas_out  = tas_q;
  assign busy_out = (state_q == ACNT_RUN);
  assign last_out = at_last;
  assign done_out = done_q;

endmodule
